nes_poll_scheduler: RTL
=======================

Name: nes_poll_scheduler

Overview:
Sequences polling of two NES pads over a shared serial clock, with a per-pad latch line. Fires a poll on a free-running frame timer or on a host request. For each pad it runs the latch and shift protocol, then publishes active-high button words plus one-cycle press-edge pulses. It sits between the pad connector pins and game/LED logic, and replaces ad-hoc per-pad controller instantiation.

Parameters:
HALF, 300, clk cycles per sclk half-period; latch lasts 2*HALF cycles (6 us / 12 us at 50 MHz); must be >= 2.
POLL_PERIOD, 833333, clk cycles between timer ticks (60 Hz at 50 MHz); must be > 34*HALF+1.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = timer ticks start polls; 0 = ticks ignored
poll_req  in  1  one-cycle host request for an immediate poll
sdata0  in  1  serial data from pad 0, active-low
sdata1  in  1  serial data from pad 1, active-low
latch0  out  1  latch to pad 0
latch1  out  1  latch to pad 1
sclk  out  1  shared serial clock
busy  out  1  high from poll start through the DONE cycle
state  out  2  FSM state: 0 IDLE, 1 LATCH, 2 SHIFT, 3 DONE
buttons0  out  8  pad 0 buttons, active-high; bit0..7 = A, B, Select, Start, Up, Down, Left, Right
buttons1  out  8  pad 1 buttons, same bit order
pressed0  out  8  pad 0 rising-edge pulses, valid only with valid
pressed1  out  8  pad 1 rising-edge pulses
valid  out  1  one-cycle pulse when both button words have updated

Behaviour:
- Reset is synchronous and active-high; clk is the single clock.
- Reset values: all outputs 0, including latch0/1 and sclk, and state = IDLE. Poll timer = 0 and pending = 0.
- Reset asserted mid-poll: abort immediately; on the next edge all outputs return to their reset values. No partial update of buttons0/1.
- Poll timer:
  - Free-running; counts 0..POLL_PERIOD-1.
  - tick = 1 in the cycle the count wraps to 0.
  - Runs regardless of enable.
- Start condition: a start occurs in IDLE when (tick & enable) | poll_req | pending.
- pending:
  - Set when (tick & enable) or poll_req arrives while busy.
  - Holds at most one poll; extra requests are dropped.
  - Cleared when the queued poll starts.
- enable falling mid-poll: the current poll completes normally.
- IDLE -> LATCH (pad 0):
  - latch0 = 1 for exactly 2*HALF cycles; sclk = 0.
- SHIFT, per pad, for bit k = 0..7:
  - Low phase of HALF cycles with sclk = 0. sdata is sampled in its last cycle and stored as ~sdata into bit k of a shadow register.
  - For k < 7, a high phase of HALF cycles with sclk = 1 follows.
  - After bit 7 of pad 0: go to LATCH for pad 1 (latch1) with no gap.
  - After bit 7 of pad 1: go to DONE.
- Per-pad duration: 17*HALF cycles. Start to DONE: 34*HALF cycles.
- DONE (1 cycle):
  - buttons0/1 load from the shadow registers.
  - pressed0/1 = shadow & ~previous buttons, in the same cycle.
  - valid = 1.
  - Next cycle: IDLE. valid and pressed return to 0.
- A pending poll starts on the cycle after DONE (IDLE lasts exactly 1 cycle).
- latch0 and latch1 are never high together; sclk is never high while either latch is high.
- Counter widths: $clog2 of their terminal values; no wrap beyond the terminal count.

Decomposition:
- Package nes_pkg:
  - button index constants (BTN_A=0 .. BTN_RIGHT=7)
  - state encoding constants (ST_IDLE..ST_DONE)
  - bit count constant NES_BITS=8
- Sub-module nes_serial_engine:
  - single-pad latch/shift sequencer with start/done handshake, HALF parameter, and latch/sclk/sdata/shadow-data ports.
  - Instantiated once and time-multiplexed by a pad-select bit.
  - The top level owns the timer, pending flag, output registers and edge detection.

Test Plan:
- HALF=4, POLL_PERIOD=200, enable=1, pad0 sends bit pattern 10111110 (bit0 first, active-low) -> after 136 cycles from tick: valid pulse, buttons0=0x41 (A + Left), state=3 for 1 cycle.
- Same poll repeated, with pad0 newly pressing Start (pattern bit3=0) -> pressed0=0x08 with valid only; buttons0=0x49; second identical poll gives pressed0=0x00.
- poll_req pulsed twice while busy -> exactly one extra poll, starting 1 cycle after DONE; a third request in the same busy window is dropped.
- enable=0 and no poll_req for 1000 cycles -> latch0/1 and sclk stay 0, busy=0, no valid.
- reset asserted 50 cycles into a poll -> next edge: state=0, sclk=0, latch0/1=0, buttons unchanged at 0, busy=0.
- Protocol monitor over 10 polls -> latch high width exactly 8 cycles, 7 sclk pulses of 4 cycles per pad, latches never overlap.

Source files
------------

// File: rtl/nes_pkg.sv
// Shared constants for the NES pad poller: button bit positions, FSM
// encoding and the serial frame length.
package nes_pkg;

    // Bits shifted out of one pad per latch
    localparam int NES_BITS = 8;

    // Button bit positions in the published words (first bit shifted = bit 0)
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    // Scheduler FSM encoding, exported on the state port
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One pad frame in half-period segments: two latch segments, then
    // alternating low/high sclk segments ending on the low phase of the
    // last bit. Segment numbers therefore run 0 .. 2*NES_BITS.
    localparam int SEG_LAST = 2 * NES_BITS;

endpackage

// File: rtl/nes_serial_engine.sv
// Single-pad latch/shift sequencer. A start pulse launches a frame: latch
// for two half-periods, then NES_BITS low phases separated by sclk-high
// phases. Data is sampled in the last cycle of each low phase. The engine
// restarts cleanly if start arrives in its final cycle, so two pads can be
// read back to back with no gap.
module nes_serial_engine
    import nes_pkg::*;
#(
    parameter int HALF = 300
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                sdata,
    output logic                latch,
    output logic                sclk,
    output logic                latch_last,
    output logic                done,
    output logic [NES_BITS-1:0] data
);

    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int SW = $clog2(SEG_LAST + 1);
    localparam int BW = $clog2(NES_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);
    localparam logic [SW-1:0] SEG_END  = SW'(SEG_LAST);

    logic                active_reg;
    logic [CW-1:0]       cnt_reg;
    logic [SW-1:0]       seg_reg;
    logic [NES_BITS-1:0] shadow_reg;

    logic                phase_end;
    logic                sample;
    logic [BW-1:0]       bit_idx;

    // Segment bookkeeping: even segments >= 2 are bit low phases, odd
    // segments >= 3 are sclk-high phases.
    assign phase_end  = active_reg && (cnt_reg == CNT_LAST);
    assign sample     = phase_end && !seg_reg[0] && (seg_reg >= SW'(2));
    assign bit_idx    = seg_reg[BW:1] - BW'(1);
    assign latch      = active_reg && (seg_reg < SW'(2));
    assign sclk       = active_reg && seg_reg[0] && (seg_reg != SW'(1));
    assign latch_last = phase_end && (seg_reg == SW'(1));
    assign done       = phase_end && (seg_reg == SEG_END);

    // Shadow word including the bit being sampled this cycle, so the
    // caller can capture a complete byte on the done cycle.
    always_comb begin
        data = shadow_reg;
        if (sample) begin
            data[bit_idx] = ~sdata;
        end
    end

    // Frame sequencing: half-period counter nested inside the segment counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_reg <= 1'b0;
            cnt_reg    <= '0;
            seg_reg    <= '0;
            shadow_reg <= '0;
        end else begin
            if (sample) begin
                shadow_reg <= data;
            end
            if (start) begin
                active_reg <= 1'b1;
                cnt_reg    <= '0;
                seg_reg    <= '0;
            end else if (active_reg) begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_reg <= '0;
                    if (seg_reg == SEG_END) begin
                        active_reg <= 1'b0;
                    end else begin
                        seg_reg <= seg_reg + SW'(1);
                    end
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/nes_poll_scheduler.sv
// Two-pad NES poll scheduler. A free-running frame timer (or a host
// request) starts a poll; one serial engine reads pad 0 then pad 1 over
// the shared sclk, and the DONE cycle publishes both button words with
// press-edge pulses. One extra request arriving mid-poll is queued.
module nes_poll_scheduler
    import nes_pkg::*;
#(
    parameter int HALF        = 300,
    parameter int POLL_PERIOD = 833333
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                poll_req,
    input  logic                sdata0,
    input  logic                sdata1,
    output logic                latch0,
    output logic                latch1,
    output logic                sclk,
    output logic                busy,
    output logic [1:0]          state,
    output logic [NES_BITS-1:0] buttons0,
    output logic [NES_BITS-1:0] buttons1,
    output logic [NES_BITS-1:0] pressed0,
    output logic [NES_BITS-1:0] pressed1,
    output logic                valid
);

    localparam int TW = $clog2(POLL_PERIOD);
    localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_PERIOD - 1);

    state_t              state_reg;
    state_t              state_next;
    logic [TW-1:0]       timer_reg;
    logic                tick;
    logic                start_cond;
    logic                pending_reg;
    logic                pad_sel_reg;
    logic [NES_BITS-1:0] shadow0_reg;
    logic [NES_BITS-1:0] buttons0_reg;
    logic [NES_BITS-1:0] buttons1_reg;
    logic [NES_BITS-1:0] pressed0_reg;
    logic [NES_BITS-1:0] pressed1_reg;
    logic                valid_reg;
    logic [NES_BITS-1:0] rise0;
    logic [NES_BITS-1:0] rise1;

    logic                eng_start;
    logic                eng_sdata;
    logic                eng_latch;
    logic                eng_sclk;
    logic                eng_latch_last;
    logic                eng_done;
    logic [NES_BITS-1:0] eng_data;

    assign tick       = (timer_reg == TIMER_LAST);
    assign start_cond = (tick && enable) || poll_req || pending_reg;

    nes_serial_engine #(
        .HALF (HALF)
    ) u_engine (
        .clk        (clk),
        .reset      (reset),
        .start      (eng_start),
        .sdata      (eng_sdata),
        .latch      (eng_latch),
        .sclk       (eng_sclk),
        .latch_last (eng_latch_last),
        .done       (eng_done),
        .data       (eng_data)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state: pad 0 frame, pad 1 frame, one publish cycle
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start_cond)     state_next = ST_LATCH;
            ST_LATCH: if (eng_latch_last) state_next = ST_SHIFT;
            ST_SHIFT: if (eng_done)       state_next = pad_sel_reg ? ST_DONE : ST_LATCH;
            ST_DONE:                      state_next = ST_IDLE;
            default:                      state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: engine launch, pad routing of latch and data
    always_comb begin
        busy      = (state_reg != ST_IDLE);
        eng_start = ((state_reg == ST_IDLE) && start_cond) || (eng_done && !pad_sel_reg);
        latch0    = eng_latch && !pad_sel_reg;
        latch1    = eng_latch && pad_sel_reg;
        eng_sdata = pad_sel_reg ? sdata1 : sdata0;
    end

    assign sclk     = eng_sclk;
    assign state    = state_reg;
    assign buttons0 = buttons0_reg;
    assign buttons1 = buttons1_reg;
    assign pressed0 = pressed0_reg;
    assign pressed1 = pressed1_reg;
    assign valid    = valid_reg;

    // Frame timer, free running independent of enable
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_reg <= '0;
        end else if (tick) begin
            timer_reg <= '0;
        end else begin
            timer_reg <= timer_reg + TW'(1);
        end
    end

    // Poll queue, pad select and pad 0 capture
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_reg <= 1'b0;
            pad_sel_reg <= 1'b0;
            shadow0_reg <= '0;
        end else begin
            // In IDLE any queued poll is being launched right now
            if (state_reg == ST_IDLE) begin
                pending_reg <= 1'b0;
            end else if ((tick && enable) || poll_req) begin
                pending_reg <= 1'b1;
            end

            if (eng_done && !pad_sel_reg) begin
                pad_sel_reg <= 1'b1;
                shadow0_reg <= eng_data;
            end else if (state_reg == ST_DONE) begin
                pad_sel_reg <= 1'b0;
            end
        end
    end

    // Per-bit press edges: new word high where the published word was low
    generate
        for (genvar gi = 0; gi < NES_BITS; gi++) begin : g_edge
            assign rise0[gi] = shadow0_reg[gi] & ~buttons0_reg[gi];
            assign rise1[gi] = eng_data[gi]    & ~buttons1_reg[gi];
        end
    endgenerate

    // Publish both words together on entry to DONE; pulses last one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            buttons0_reg <= '0;
            buttons1_reg <= '0;
            pressed0_reg <= '0;
            pressed1_reg <= '0;
            valid_reg    <= 1'b0;
        end else begin
            valid_reg    <= 1'b0;
            pressed0_reg <= '0;
            pressed1_reg <= '0;
            if (eng_done && pad_sel_reg) begin
                buttons0_reg <= shadow0_reg;
                buttons1_reg <= eng_data;
                pressed0_reg <= rise0;
                pressed1_reg <= rise1;
                valid_reg    <= 1'b1;
            end
        end
    end

endmodule
